// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter: a 2-entry {addr, data} FIFO per requester feeding a
// registered one-hot write port. Define REGFILE_ARB_RR_EN for round-robin, otherwise A has priority.
module regfile_write_arbiter #(
   parameter int unsigned RST_PRIO         = 0,
   parameter int unsigned ZERO_REG_PROTECT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_addr,
   input  logic [31:0] b_data,
   output logic        regWrite,
   output logic [31:0] decOut,
   output logic [31:0] writeData,
   output logic        idle,
   output logic [7:0]  drop_cnt
);

   // Index 0 is requester A, index 1 is requester B; entries are {addr, data}.
   logic [36:0]       mem_q [2][2];
   logic [1:0]        wr_ptr_q, rd_ptr_q;
   logic [1:0][1:0]   cnt_q, cnt_d;
   logic [1:0][36:0]  entry_in, head;
   logic [1:0]        ready, push, grant, nonempty;

   logic [36:0]       sel_entry;
   logic              any_grant, drop, do_write;

   logic              reg_write_q;
   logic [31:0]       dec_q, wdata_q;
   logic [7:0]        drop_cnt_q;

   assign entry_in[0] = {a_addr, a_data};
   assign entry_in[1] = {b_addr, b_data};

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         nonempty[i] = (cnt_q[i] != 2'd0);
         ready[i]    = (cnt_q[i] < 2'd2);
         head[i]     = mem_q[i][rd_ptr_q[i]];
      end
   end

   assign push[0] = a_valid & ready[0];
   assign push[1] = b_valid & ready[1];

`ifdef REGFILE_ARB_RR_EN
   // prio_q names the side that wins the next contended cycle (0 = A, 1 = B).
   logic prio_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio_q <= (RST_PRIO != 0);
      end else if (&nonempty) begin
         prio_q <= ~prio_q;
      end
   end
`else
   logic unused_rst_prio;
   assign unused_rst_prio = (RST_PRIO != 0);
`endif

   always_comb begin
      grant = 2'b00;
      unique case (nonempty)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
`ifdef REGFILE_ARB_RR_EN
         2'b11:   grant = prio_q ? 2'b10 : 2'b01;
`else
         2'b11:   grant = 2'b01;
`endif
         default: grant = 2'b00;
      endcase
   end

   assign any_grant = |grant;
   assign sel_entry = grant[1] ? head[1] : head[0];
   assign drop      = any_grant && (ZERO_REG_PROTECT != 0) && (sel_entry[36:32] == 5'd0);
   assign do_write  = any_grant & ~drop;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = cnt_q[i] + 2'(push[i]) - 2'(grant[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         for (int i = 0; i < 2; i++) begin
            if (push[i])  wr_ptr_q[i] <= ~wr_ptr_q[i];
            if (grant[i]) rd_ptr_q[i] <= ~rd_ptr_q[i];
         end
      end
   end

   // Storage needs no reset: the counts gate every read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= entry_in[i];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reg_write_q <= 1'b0;
         dec_q       <= '0;
         wdata_q     <= '0;
         drop_cnt_q  <= '0;
      end else begin
         reg_write_q <= do_write;
         dec_q       <= do_write ? (32'd1 << sel_entry[36:32]) : 32'd0;
         if (do_write) wdata_q <= sel_entry[31:0];
         if (drop && (drop_cnt_q != 8'hff)) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   assign a_ready   = ready[0];
   assign b_ready   = ready[1];
   assign regWrite  = reg_write_q;
   assign decOut    = dec_q;
   assign writeData = wdata_q;
   assign drop_cnt  = drop_cnt_q;
   assign idle      = ~|nonempty & ~reg_write_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based reference model plus directed and random steps.
// Follows REGFILE_ARB_RR_EN the same way the design does.
module tb_regfile_write_arbiter;

   localparam int unsigned RstPrio = 0;
   localparam int unsigned Zrp     = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic [4:0]  a_addr, b_addr;
   logic [31:0] a_data, b_data;
   logic        regWrite;
   logic [31:0] decOut, writeData;
   logic        idle;
   logic [7:0]  drop_cnt;

   int errors = 0;
   int checks = 0;

   // Reference state: per-requester queues and the expected write-port values.
   logic [36:0] qa[$];
   logic [36:0] qb[$];
   int          obs[$];
   bit          exp_rw;
   logic [31:0] exp_dec, exp_wd;
   int          exp_drop;
`ifdef REGFILE_ARB_RR_EN
   bit          turn;
`endif

   regfile_write_arbiter #(
      .RST_PRIO         (RstPrio),
      .ZERO_REG_PROTECT (Zrp)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .regWrite  (regWrite),
      .decOut    (decOut),
      .writeData (writeData),
      .idle      (idle),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic int dec2addr(input logic [31:0] d);
      for (int k = 0; k < 32; k++) if (d[k]) return k;
      return -1;
   endfunction

   task automatic model_reset();
      qa.delete();
      qb.delete();
      exp_rw   = 1'b0;
      exp_dec  = '0;
      exp_wd   = '0;
      exp_drop = 0;
`ifdef REGFILE_ARB_RR_EN
      turn = (RstPrio != 0);
`endif
   endtask

   // One rising edge of the specified behaviour.
   task automatic model_edge(input bit va, input logic [4:0] aa, input logic [31:0] ad,
                             input bit vb, input logic [4:0] ba, input logic [31:0] bd);
      bit          pa, pb, ga, gb;
      logic [36:0] e;
      pa = va && (qa.size() < 2);
      pb = vb && (qb.size() < 2);
      ga = 1'b0;
      gb = 1'b0;
      e  = '0;
      if (qa.size() > 0 && qb.size() > 0) begin
`ifdef REGFILE_ARB_RR_EN
         if (!turn) ga = 1'b1; else gb = 1'b1;
         turn = !turn;
`else
         ga = 1'b1;
`endif
      end else if (qa.size() > 0) begin
         ga = 1'b1;
      end else if (qb.size() > 0) begin
         gb = 1'b1;
      end
      if (ga) e = qa.pop_front();
      else if (gb) e = qb.pop_front();
      exp_rw  = 1'b0;
      exp_dec = '0;
      if (ga || gb) begin
         if (Zrp != 0 && e[36:32] == 5'd0) begin
            if (exp_drop < 255) exp_drop++;
         end else begin
            exp_rw  = 1'b1;
            exp_dec = 32'd1 << e[36:32];
            exp_wd  = e[31:0];
         end
      end
      if (pa) qa.push_back({aa, ad});
      if (pb) qb.push_back({ba, bd});
   endtask

   task automatic step(input bit va, input logic [4:0] aa, input logic [31:0] ad,
                       input bit vb, input logic [4:0] ba, input logic [31:0] bd);
      @(negedge clk);
      a_valid = va; a_addr = aa; a_data = ad;
      b_valid = vb; b_addr = ba; b_data = bd;
      #1;
      chk("a_ready", 32'(a_ready), 32'(qa.size() < 2));
      chk("b_ready", 32'(b_ready), 32'(qb.size() < 2));
      model_edge(va, aa, ad, vb, ba, bd);
      @(posedge clk);
      #1;
      chk("regWrite", 32'(regWrite), 32'(exp_rw));
      chk("decOut", decOut, exp_dec);
      chk("writeData", writeData, exp_wd);
      chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
      chk("idle", 32'(idle), 32'(qa.size() == 0 && qb.size() == 0 && !exp_rw));
      if (regWrite === 1'b1) obs.push_back(dec2addr(decOut));
   endtask

   task automatic idle_steps(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      int          a_idx;
      logic [4:0]  a_beats [3];
      int          exp_order [4];
      reset   = 1'b0;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;
      model_reset();

      // Reset state.
      #3;
      chk("rst_regWrite", 32'(regWrite), 32'd0);
      chk("rst_decOut", decOut, 32'd0);
      chk("rst_writeData", writeData, 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      chk("rst_a_ready", 32'(a_ready), 32'd1);
      chk("rst_b_ready", 32'(b_ready), 32'd1);
      chk("rst_idle", 32'(idle), 32'd1);

      // Release so that the first push lands on the first edge after release.
      @(posedge clk);
      #1 reset = 1'b1;
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("first_regWrite", 32'(regWrite), 32'd1);
      chk("first_decOut", decOut, 32'h0000_0020);
      chk("first_writeData", writeData, 32'hDEADBEEF);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("first_one_cycle", 32'(regWrite), 32'd0);

      // Two entries each from A (addr 1,2) and B (addr 3,4).
      obs.delete();
      step(1'b1, 5'd1, 32'hA0, 1'b1, 5'd3, 32'hB0);
      step(1'b1, 5'd2, 32'hA1, 1'b1, 5'd4, 32'hB1);
      idle_steps(5);
`ifdef REGFILE_ARB_RR_EN
      exp_order = '{1, 3, 2, 4};
`else
      exp_order = '{1, 2, 3, 4};
`endif
      chk("order_count", 32'(obs.size()), 32'd4);
      for (int k = 0; k < 4 && k < obs.size(); k++) chk("order", 32'(obs[k]), 32'(exp_order[k]));

      // Register-0 writes are discarded and counted, saturating.
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd1);
      idle_steps(2);
      chk("drop_one", 32'(drop_cnt), 32'd1);
      for (int k = 0; k < 300; k++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd1);
      idle_steps(3);
      chk("drop_sat", 32'(drop_cnt), 32'd255);

      // Three A beats held until accepted while B stays busy.
      a_beats = '{5'd7, 5'd8, 5'd9};
      a_idx = 0;
      for (int k = 0; k < 20 && a_idx < 3; k++) begin
         bit ok;
         ok = (qa.size() < 2);
         step(1'b1, a_beats[a_idx], 32'h100 + 32'(a_idx), 1'b1, 5'(10 + k % 8), 32'h200 + 32'(k));
         if (ok) a_idx++;
      end
      chk("a_beats_accepted", 32'(a_idx), 32'd3);
      idle_steps(6);

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
      end

      // Reset with entries queued: outputs clear immediately, nothing issues afterwards.
      step(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h12);
      step(1'b1, 5'd13, 32'h13, 1'b1, 5'd14, 32'h14);
      step(1'b1, 5'd15, 32'h15, 1'b1, 5'd16, 32'h16);
      @(negedge clk);
      a_valid = 1'b0;
      b_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_regWrite", 32'(regWrite), 32'd0);
      chk("mid_rst_decOut", decOut, 32'd0);
      chk("mid_rst_writeData", writeData, 32'd0);
      chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
      chk("mid_rst_a_ready", 32'(a_ready), 32'd1);
      chk("mid_rst_b_ready", 32'(b_ready), 32'd1);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_steps(3);
      chk("final_idle", 32'(idle), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter RST_PRIO, default 0: initial round-robin pointer (0 = A first, 1 = B first).
REQ-002 SHALL have parameter ZERO_REG_PROTECT, default 1: 1 = writes to register 0 are discarded.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports a_valid  input  1 / a_ready  output  1: requester A handshake (ALU writeback).
REQ-006 SHALL have ports a_addr  input  5 / a_data  input  32: requester A destination register and value.
REQ-007 SHALL have ports b_valid  input  1 / b_ready  output  1 / b_addr  input  5 / b_data  input  32: requester B (load writeback), same meaning.
REQ-008 SHALL have ports regWrite  output  1 / decOut  output  32 / writeData  output  32: register-file write port; decOut one-hot per register.
REQ-009 SHALL have ports idle  output  1 (both FIFOs empty and no write issued this cycle) / drop_cnt  output  8 (discarded register-0 writes).

Function
REQ-010 SHALL hold a 2-entry FIFO per requester storing {addr, data}.
REQ-011 SHALL push on a rising edge when valid=1 and ready=1; ready = (FIFO count < 2), derived from registered count only, independent of the same-cycle pop.
REQ-012 SHALL pop at most one entry in total per cycle, from the granted FIFO.
REQ-013 SHALL grant as follows: only one FIFO non-empty -> grant it; both non-empty -> grant per the rule in REQ-027; both empty -> no grant.
REQ-014 SHALL, one cycle after a grant, drive regWrite=1, decOut=(1<<addr), writeData=data from registered outputs; latency from push to regWrite = 2 cycles minimum.
REQ-015 SHALL, with no grant, drive regWrite=0, decOut=0, and hold writeData at its last value.
REQ-016 SHALL, when ZERO_REG_PROTECT=1 and the granted addr=0, pop the entry, drive regWrite=0 and decOut=0, and increment drop_cnt, saturating at 255.
REQ-017 SHALL preserve order within each requester; no ordering between A and B is guaranteed.
REQ-018 SHALL accept a push and a pop on the same FIFO in the same cycle (count unchanged), including at count=1.
REQ-019 SHALL at most update the round-robin pointer on a cycle where both FIFOs are non-empty and a grant occurs.
REQ-020 SHALL ignore a_addr/a_data when a_valid=0, and ignore a_valid while a_ready=0 (no push, no error); B likewise.

Reset
REQ-021 SHALL, while reset=0, asynchronously clear both FIFO counts and pointers and drive regWrite=0, decOut=0, writeData=0, drop_cnt=0.
REQ-022 SHALL drive a_ready=1, b_ready=1 and idle=1 out of reset.
REQ-023 SHALL load the round-robin pointer with RST_PRIO on reset.
REQ-024 SHALL, on reset mid-operation, discard all queued entries; no write issues on the first edge after release.
REQ-025 SHALL release reset cleanly on a rising edge with valid inputs: the first push is accepted on that edge.

Configuration
REQ-026 SHALL use macro REGFILE_ARB_RR_EN to select the arbitration policy.
REQ-027 SHALL, with REGFILE_ARB_RR_EN defined, arbitrate round-robin: when both FIFOs are non-empty, grant the pointer side, then point to the other side; without it, use fixed priority: A always wins, pointer unused and RST_PRIO ignored.

Verification
REQ-028 SHALL cover: reset, then A pushes addr=5 data=0xDEADBEEF -> 2 cycles later regWrite=1, decOut=0x00000020, writeData=0xDEADBEEF for one cycle.
REQ-029 SHALL cover: A and B each push 2 entries at once with RR enabled, RST_PRIO=0 -> write order A0,B0,A1,B1; with fixed priority -> A0,A1,B0,B1.
REQ-030 SHALL cover: B pushes addr=0 data=0x1 -> regWrite stays 0, drop_cnt 0->1; 300 such pushes -> drop_cnt=255.
REQ-031 SHALL cover: A pushes 3 consecutive cycles while B keeps both FIFOs busy -> a_ready=0 after the 2nd push, 3rd beat held and accepted later, no loss, no duplication.
REQ-032 SHALL cover: assert reset=0 with 2 entries queued in each FIFO -> outputs 0 immediately; after release no write issues and ready=1.
